// File: rtl/water_sensor_filter.sv
// Float-switch conditioner: 2-flop sync, per-bit debounce, plausibility FSM; latency DEBOUNCE_CYCLES+3 edges.
// Free-running with no backpressure; level_valid/sensor_fault qualify the high/mid/low outputs.
module water_sensor_filter #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FAULT_CYCLES    = 64,
    parameter int CNT_W           = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_high,
    input  logic raw_mid,
    input  logic raw_low,
    output logic high,
    output logic mid,
    output logic low,
    output logic level_valid,
    output logic sensor_fault
);

    localparam logic [1:0] ST_INIT    = 2'd0;
    localparam logic [1:0] ST_OK      = 2'd1;
    localparam logic [1:0] ST_SUSPECT = 2'd2;
    localparam logic [1:0] ST_FAULT   = 2'd3;

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(DEBOUNCE_CYCLES + 2);
    localparam logic [CNT_W-1:0] FAULT_LAST  = CNT_W'(FAULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] FAULT_PRE   = CNT_W'(FAULT_CYCLES - 2);

    logic [2:0]       raw_vec;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       stable;
    logic [CNT_W-1:0] deb_cnt [3];
    logic             plausible;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] settle_cnt;
    logic [CNT_W-1:0] settle_nxt;
    logic [CNT_W-1:0] fault_cnt;
    logic [CNT_W-1:0] fault_nxt;
    logic [2:0]       last_good;

    assign raw_vec = {raw_high, raw_mid, raw_low};

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_vec;
            sync2 <= sync1;
        end
    end

    // A mismatch must persist DEBOUNCE_CYCLES consecutive cycles; any match clears the count.
    always_ff @(posedge clock) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] >= DEB_LAST) begin
                    stable[i]  <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Water fills bottom-up, so a wet switch must have every switch below it wet.
    assign plausible = (stable == 3'b000) || (stable == 3'b001) ||
                       (stable == 3'b011) || (stable == 3'b111);

    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        fault_nxt  = fault_cnt;
        case (state)
            ST_INIT: begin
                if (settle_cnt >= SETTLE_LAST) begin
                    state_nxt = plausible ? ST_OK : ST_SUSPECT;
                    fault_nxt = '0;
                end else begin
                    settle_nxt = settle_cnt + CNT_W'(1);
                end
            end
            ST_OK: begin
                if (!plausible) begin
                    state_nxt = ST_SUSPECT;
                    fault_nxt = '0;
                end
            end
            ST_SUSPECT: begin
                // The cycle that entered SUSPECT was already implausible, hence FAULT_PRE.
                if (plausible) begin
                    state_nxt = ST_OK;
                    fault_nxt = '0;
                end else if (fault_cnt >= FAULT_PRE) begin
                    state_nxt = ST_FAULT;
                    fault_nxt = '0;
                end else begin
                    fault_nxt = fault_cnt + CNT_W'(1);
                end
            end
            ST_FAULT: begin
                if (!plausible) begin
                    fault_nxt = '0;
                end else if (fault_cnt >= FAULT_LAST) begin
                    state_nxt = ST_OK;
                    fault_nxt = '0;
                end else begin
                    fault_nxt = fault_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt  = ST_INIT;
                settle_nxt = '0;
                fault_nxt  = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so a bad pattern never leaks out for a cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_INIT;
            settle_cnt   <= '0;
            fault_cnt    <= '0;
            last_good    <= '0;
            high         <= 1'b0;
            mid          <= 1'b0;
            low          <= 1'b0;
            level_valid  <= 1'b0;
            sensor_fault <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_nxt;
            fault_cnt  <= fault_nxt;
            case (state_nxt)
                ST_OK: begin
                    last_good        <= stable;
                    {high, mid, low} <= stable;
                    level_valid      <= 1'b1;
                    sensor_fault     <= 1'b0;
                end
                ST_SUSPECT: begin
                    {high, mid, low} <= last_good;
                    level_valid      <= 1'b1;
                    sensor_fault     <= 1'b0;
                end
                ST_FAULT: begin
                    {high, mid, low} <= 3'b000;
                    level_valid      <= 1'b0;
                    sensor_fault     <= 1'b1;
                end
                default: begin
                    {high, mid, low} <= 3'b000;
                    level_valid      <= 1'b0;
                    sensor_fault     <= 1'b0;
                end
            endcase
        end
    end

endmodule
